wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter: the producer end of the register file write port. It merges results from the single-cycle ALU path and the long-latency load/store (LSU) path onto the single write port (`wr_en`/`wr_idx`/`wr_data`). LSU results wait in a 2-entry buffer. A 32-bit pending-destination scoreboard tells the issue stage which registers have writes outstanding.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: LSU result buffer entries. Only 2 is supported.
- `STARVE_LIMIT`, default 3: number of consecutive ALU wins over a non-empty buffer before the buffer is forced.

Ports:
- `clk`  in  1  clock, all flops on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `alu_valid`  in  1  ALU result present.
- `alu_idx`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`.
- `lsu_valid`  in  1  LSU result present.
- `lsu_idx`  in  5  LSU destination register.
- `lsu_data`  in  32  LSU result.
- `lsu_ready`  out  1  buffer can accept an LSU result.
- `iss_en`  in  1  issue stage dispatched an instruction that has a destination.
- `iss_idx`  in  5  destination of the issued instruction.
- `flush`  in  1  pipeline flush.
- `wr_en`  out  1  register file write enable, registered.
- `wr_idx`  out  5  register file write index, registered.
- `wr_data`  out  32  register file write data, registered.
- `pend_mask`  out  32  bit i set means register i has a write outstanding, registered.

## Operation
- **Handshakes.** Valid/ready on both producer ports. A transfer occurs on any edge where valid and ready are both 1. Producers hold `idx`/`data` stable while valid is high and ready is low.
- **LSU path.** `lsu_ready` = (count < 2) && !`flush`. An accepted LSU result is pushed into the buffer. There is no push-through when the buffer is full.
- **Write-port selection**, evaluated each cycle:
  - `flush`: nothing is selected, `alu_ready` = 0, `lsu_ready` = 0.
  - Else if the buffer is non-empty and `starve_cnt` == `STARVE_LIMIT`: the buffer head wins, `alu_ready` = 0, and `starve_cnt` is cleared.
  - Else if `alu_valid`: the ALU wins and `alu_ready` = 1. If the buffer is non-empty, `starve_cnt` increments.
  - Else if the buffer is non-empty: the head pops and wins, and `starve_cnt` is cleared.
  - `alu_ready` = 1 whenever the forced case does not apply and `flush` = 0, independent of `alu_valid`.
- **Write registration.** The winner's index and data are registered into `wr_idx`/`wr_data`. `wr_en` is registered as 1 unless the index equals `ZERO_REG`. Index-0 results are consumed but never written.
- **Scoreboard.** A bit is set on `iss_en` for `iss_idx` ≠ 0. The winner's bit is cleared on the accept edge. If set and clear hit the same index in one cycle, set wins. Bit 0 is always 0.
- **Flush.** On the edge where `flush` = 1:
  - buffer is emptied, `pend_mask` = 0, `starve_cnt` = 0, and `iss_en` is ignored that cycle;
  - `wr_en` is registered as 0;
  - a write already registered on the previous edge still appears on `wr_*` for its one cycle.
- **Reset.** Asserting `rst_n` low in the middle of operation immediately clears the buffer, counter and scoreboard and zeroes all registered outputs.

## Timing
- **Reset values:** `wr_en` = 0, `wr_idx` = 0, `wr_data` = 0, `pend_mask` = 0, buffer count = 0, `starve_cnt` = 0. After reset `alu_ready` = 1 and `lsu_ready` = 1.
- **ALU latency:** accepted at edge N, `wr_*` valid during cycle N+1.
- **LSU latency:** pushed at edge N, earliest pop at edge N+1, `wr_*` valid during cycle N+2.
- **Throughput:** at most one register-file write per cycle.
- **Buffer order:** strict FIFO. Pointers are 1 bit and count is 2 bits; pointers wrap modulo 2.
- **Buffer at capacity:** push and pop in the same cycle are allowed only when count < 2.
- **Starvation bound:** with the buffer non-empty and the ALU valid every cycle, the buffer head is written no later than the (`STARVE_LIMIT`+1)th cycle.

## Structure
- `sys_defs.vh` supplies `ZERO_REG`.
- Add `WB_FIFO_DEPTH` and `WB_STARVE_LIMIT` to `sys_defs.vh`.
- Sub-module `wb_fifo`: 2-entry, 37-bit (idx+data) synchronous FIFO with push, pop, clear, count, and an asynchronous active-low reset.
- `wb_arbiter` holds the selection logic, `starve_cnt`, the scoreboard and the output registers.

## Test plan
- **Reset, then ALU write.** Reset; ALU writes idx 5, data 0xDEADBEEF. Required: `wr_en` = 1, `wr_idx` = 5, `wr_data` = 0xDEADBEEF exactly one cycle later; `wr_en` = 0 before that.
- **LSU buffer full.** Two LSU pushes (idx 3/0x11, idx 4/0x22) with the ALU idle. Required: writes appear in order on cycles N+2 and N+3. While count = 2, `lsu_ready` = 0.
- **Starvation.** Buffer holds 1 entry and `alu_valid` is held for 6 cycles with idx 1..6. Required: ALU wins 3 times, then the buffer head is written with `alu_ready` = 0 for that cycle, then the ALU resumes.
- **Scoreboard.**
  - Issue idx 7 → `pend_mask[7]` = 1 next cycle.
  - ALU writeback of idx 7 in the same cycle as a new issue of idx 7 → bit stays 1.
  - Issue idx 0 → `pend_mask` is unchanged.
- **Zero register.** ALU result to idx 0 with data 0xFFFFFFFF → accepted (`alu_ready` = 1), `wr_en` stays 0.
- **Flush and reset.** Flush with the buffer full and `pend_mask` = 0x0000_00F0 → next cycle count = 0, `pend_mask` = 0, and both readys go 1 again. Then assert `rst_n` low mid-transfer → all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter and its LSU result buffer.
package wb_arbiter_pkg;

    // Architectural zero register: results targeting it are consumed but never written.
    localparam int ZERO_REG        = 0;
    // Default LSU buffer depth and starvation threshold.
    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_STARVE_LIMIT = 3;

    localparam int IDX_W   = 5;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = IDX_W + DATA_W;

    // True when the destination is the hardwired zero register.
    function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding LSU results ({idx, data}) until they win the write port.
// Push is ignored when full and pop is ignored when empty; clear has priority over both.
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [1:0]         count_o
);

    logic [ENTRY_W-1:0] mem_q [WB_FIFO_DEPTH];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               push_ok;
    logic               pop_ok;

    // Qualify push/pop against occupancy and derive the next count.
    always_comb begin
        push_ok = push_i && (count_q != 2'd2);
        pop_ok  = pop_i && (count_q != 2'd0);
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap modulo 2 by being 1 bit wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered LSU results onto
// the one register-file write port, and tracks pending destinations for issue.
//
// Handshake: on both producer ports a transfer happens on any rising edge where
// valid and ready are both 1; producers keep idx/data stable while valid is high
// and ready is low. alu_ready does not depend on alu_valid.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_idx,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_idx,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        iss_en,
    input  logic [4:0]  iss_idx,
    input  logic        flush,
    output logic        wr_en,
    output logic [4:0]  wr_idx,
    output logic [31:0] wr_data,
    output logic [31:0] pend_mask
);

    localparam int         SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_L = SW'(STARVE_LIMIT);
    localparam logic [1:0] DEPTH_L  = 2'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] head;
    logic [1:0]         count;
    logic               buf_ne;
    logic               forced;
    logic               alu_win;
    logic               buf_win;
    logic               push;
    logic [4:0]         win_idx;
    logic [31:0]        win_data;

    logic [SW-1:0]      starve_q, starve_d;
    logic [31:0]        pend_q, pend_d;
    logic               wr_en_q, wr_en_d;
    logic [4:0]         wr_idx_q, wr_idx_d;
    logic [31:0]        wr_data_q, wr_data_d;

    wb_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({lsu_idx, lsu_data}),
        .pop_i       (buf_win),
        .clear_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

    // Pick the write-port winner: flush blocks everything, a starved buffer is forced,
    // otherwise the ALU has priority and the buffer drains when the ALU is idle.
    always_comb begin
        buf_ne    = (count != 2'd0);
        forced    = !flush && buf_ne && (starve_q == STARVE_L);
        alu_ready = !flush && !forced;
        lsu_ready = !flush && (count < DEPTH_L);
        alu_win   = alu_ready && alu_valid;
        buf_win   = !flush && buf_ne && !alu_win;
        push      = lsu_valid && lsu_ready;
        win_idx   = alu_win ? alu_idx  : head[ENTRY_W-1:DATA_W];
        win_data  = alu_win ? alu_data : head[DATA_W-1:0];
    end

    // Next state for the starvation counter, scoreboard and write-port registers.
    always_comb begin
        starve_d  = starve_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (flush) begin
            starve_d = '0;
            pend_d   = '0;
        end else begin
            if (buf_win) begin
                starve_d = '0;
            end else if (alu_win && buf_ne) begin
                starve_d = starve_q + 1'b1;
            end
            if (alu_win || buf_win) begin
                wr_en_d   = !is_zero_reg(win_idx);
                wr_idx_d  = win_idx;
                wr_data_d = win_data;
                pend_d[win_idx] = 1'b0;
            end
            // A new issue to the same register outlives the retiring write.
            if (iss_en && !is_zero_reg(iss_idx)) begin
                pend_d[iss_idx] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_idx    = wr_idx_q;
    assign wr_data   = wr_data_q;
    assign pend_mask = pend_q;

endmodule
